// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line to burst adaptor.
// Optional feature macro used by this slice: CACHELINE_ADAPTOR_PERF_EN.
package cacheline_adaptor_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int CNT_W   = $clog2(BEATS);

  typedef logic [31:0]        addr_t;
  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] burst_t;
  typedef logic [CNT_W-1:0]   beat_idx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } adaptor_state_t;

  // Lines are 32 bytes, so the low five address bits select a byte in the line.
  function automatic addr_t line_align(input addr_t addr);
    return {addr[31:5], 5'b00000};
  endfunction

  // Saturating increment for the 32-bit event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundles the arbiter-side and memory-side signals of the adaptor.
// slave: the adaptor itself; master: the environment around it.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  // arbiter side
  line_t  line_i;
  line_t  line_o;
  addr_t  address_i;
  logic   read_i;
  logic   write_i;
  logic   resp_o;
  // memory side
  burst_t burst_i;
  burst_t burst_o;
  addr_t  address_o;
  logic   read_o;
  logic   write_o;
  logic   resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor_line_buffer.sv
// Line-wide data register: loaded whole on a write request, filled one
// beat at a time during a read, and read out one beat at a time for writes.
module adaptor_line_buffer
  import cacheline_adaptor_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  line_t     load_line_i,
  input  logic      beat_we_i,
  input  beat_idx_t beat_idx_i,
  input  burst_t    beat_data_i,
  input  beat_idx_t rd_idx_i,
  output line_t     line_o,
  output burst_t    beat_o
);

  line_t buf_q;
  line_t buf_d;

  // Next buffer contents: a full-line load takes priority over a beat write.
  always_comb begin
    buf_d = buf_q;
    if (load_i) begin
      buf_d = load_line_i;
    end else if (beat_we_i) begin
      buf_d[beat_idx_i*BURST_W +: BURST_W] = beat_data_i;
    end else begin
      buf_d = buf_q;
    end
  end

  // Buffer register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= {LINE_W{1'b0}};
    end else begin
      buf_q <= buf_d;
    end
  end

  assign line_o = buf_q;
  assign beat_o = buf_q[rd_idx_i*BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit line request into a 4 x 64-bit memory burst.
// Optional: define CACHELINE_ADAPTOR_PERF_EN for rd_count_o, wr_count_o,
// busy_cycles_o performance counters.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  cacheline_adaptor_if.slave bus
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o,
  output logic [31:0] busy_cycles_o
`endif
);

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  adaptor_state_t state_q, state_d;
  beat_idx_t      cnt_q, cnt_d;
  addr_t          addr_q, addr_d;
  logic           is_wr_q, is_wr_d;
  line_t          line_q, line_d;
  logic           read_q, read_d;
  logic           write_q, write_d;
  logic           resp_q, resp_d;

  logic           buf_load_s;
  logic           buf_we_s;
  line_t          buf_line_s;
  burst_t         buf_beat_s;

  adaptor_line_buffer u_line_buffer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (buf_load_s),
    .load_line_i (bus.line_i),
    .beat_we_i   (buf_we_s),
    .beat_idx_i  (cnt_q),
    .beat_data_i (bus.burst_i),
    .rd_idx_i    (cnt_q),
    .line_o      (buf_line_s),
    .beat_o      (buf_beat_s)
  );

  // Next-state, beat counting and buffer control; outputs follow next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    is_wr_d    = is_wr_q;
    line_d     = line_q;
    buf_load_s = 1'b0;
    buf_we_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.write_i) begin
          state_d    = S_WRITE;
          addr_d     = line_align(bus.address_i);
          is_wr_d    = 1'b1;
          cnt_d      = beat_idx_t'(0);
          buf_load_s = 1'b1;
        end else if (bus.read_i) begin
          state_d = S_READ;
          addr_d  = line_align(bus.address_i);
          is_wr_d = 1'b0;
          cnt_d   = beat_idx_t'(0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (bus.resp_i) begin
          buf_we_s = 1'b1;
          cnt_d    = cnt_q + beat_idx_t'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
            // The last beat lands in the top slot; publish the whole line
            // now so line_o is valid in the same cycle as resp_o.
            line_d  = {bus.burst_i, buf_line_s[LINE_W-BURST_W-1:0]};
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + beat_idx_t'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        // The arbiter only changes its request after seeing resp_o, so
        // never accept directly out of DONE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    read_d  = (state_d == S_READ);
    write_d = (state_d == S_WRITE);
    resp_d  = (state_d == S_DONE);
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= beat_idx_t'(0);
      addr_q  <= 32'h0000_0000;
      is_wr_q <= 1'b0;
      line_q  <= {LINE_W{1'b0}};
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      is_wr_q <= is_wr_d;
      line_q  <= line_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.line_o    = line_q;
  assign bus.resp_o    = resp_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.burst_o   = write_q ? buf_beat_s : {BURST_W{1'b0}};

`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;
  logic [31:0] busy_cycles_q;

  // Saturating completion and busy-cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q    <= 32'd0;
      wr_count_q    <= 32'd0;
      busy_cycles_q <= 32'd0;
    end else begin
      if ((state_q == S_DONE) && !is_wr_q) begin
        rd_count_q <= sat_inc(rd_count_q);
      end
      if ((state_q == S_DONE) && is_wr_q) begin
        wr_count_q <= sat_inc(wr_count_q);
      end
      if (state_q != S_IDLE) begin
        busy_cycles_q <= sat_inc(busy_cycles_q);
      end
    end
  end

  assign rd_count_o    = rd_count_q;
  assign wr_count_o    = wr_count_q;
  assign busy_cycles_o = busy_cycles_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  localparam line_t LINE_A = {64'hAAAA_3333_0000_0003, 64'hAAAA_2222_0000_0002,
                              64'hAAAA_1111_0000_0001, 64'hAAAA_0000_0000_0000};
  localparam line_t LINE_B = {64'hBBBB_0003_1234_5678, 64'hBBBB_0002_1234_5678,
                              64'hBBBB_0001_1234_5678, 64'hBBBB_0000_1234_5678};
  localparam line_t LINE_C = {64'hCCCC_3000_0000_00C3, 64'hCCCC_2000_0000_00C2,
                              64'hCCCC_1000_0000_00C1, 64'hCCCC_0000_0000_00C0};
  localparam line_t LINE_D = {64'hDDDD_0000_0000_0D03, 64'hDDDD_0000_0000_0D02,
                              64'hDDDD_0000_0000_0D01, 64'hDDDD_0000_0000_0D00};
  localparam line_t LINE_E = {64'hEEEE_EEEE_0000_0003, 64'hEEEE_EEEE_0000_0002,
                              64'hEEEE_EEEE_0000_0001, 64'hEEEE_EEEE_0000_0000};

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cacheline_adaptor_if bus ();

`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [31:0] busy_cycles;
`endif

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    .rd_count_o    (rd_count),
    .wr_count_o    (wr_count),
    .busy_cycles_o (busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Stimulus only: request a read and return beats; ends in the DONE cycle.
  task automatic read_line(input addr_t addr, input line_t data, input int wait_cycles);
    bus.read_i    = 1'b1;
    bus.address_i = addr;
    step();
    bus.resp_i = 1'b0;
    repeat (wait_cycles) step();
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = data[i*64 +: 64];
      step();
    end
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("FAIL reset_read_o: got %0h want 0", bus.read_o); end
    checks++; if (bus.write_o !== 1'b0) begin errors++; $display("FAIL reset_write_o: got %0h want 0", bus.write_o); end
    checks++; if (bus.resp_o !== 1'b0) begin errors++; $display("FAIL reset_resp_o: got %0h want 0", bus.resp_o); end
    checks++; if (bus.address_o !== 32'h0) begin errors++; $display("FAIL reset_address_o: got %h want 0", bus.address_o); end
    checks++; if (bus.burst_o !== 64'h0) begin errors++; $display("FAIL reset_burst_o: got %h want 0", bus.burst_o); end
    checks++; if (bus.line_o !== {LINE_W{1'b0}}) begin errors++; $display("FAIL reset_line_o: got %h want 0", bus.line_o); end
    rst = 1'b0;
    step();
  endtask

`ifdef CACHELINE_ADAPTOR_PERF_EN
  task automatic test_perf();
    read_line(32'h0000_0100, LINE_A, 1);
    bus.read_i = 1'b0;
    step();
    read_line(32'h0000_0200, LINE_B, 1);
    bus.read_i = 1'b0;
    step();
    bus.write_i = 1'b1; bus.line_i = LINE_C; bus.address_i = 32'h0000_0300;
    step();
    step();
    for (int i = 0; i < 4; i++) begin bus.resp_i = 1'b1; step(); end
    bus.resp_i = 1'b0; bus.write_i = 1'b0;
    step();
    checks++; if (rd_count !== 32'd2) begin errors++; $display("FAIL perf_rd_count: got %0d want 2", rd_count); end
    checks++; if (wr_count !== 32'd1) begin errors++; $display("FAIL perf_wr_count: got %0d want 1", wr_count); end
    checks++; if (busy_cycles !== 32'd18) begin errors++; $display("FAIL perf_busy_cycles: got %0d want 18", busy_cycles); end
  endtask
`endif

  task automatic test_read();
    line_t la = LINE_A;
    bus.read_i = 1'b1; bus.address_i = 32'h0000_1234;
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("FAIL read_latency: read_o got %0h want 0 before accept", bus.read_o); end
    step();
    checks++; if (bus.read_o !== 1'b1) begin errors++; $display("FAIL read_read_o: got %0h want 1", bus.read_o); end
    checks++; if (bus.address_o !== 32'h0000_1220) begin errors++; $display("FAIL read_address_o: got %h want 00001220", bus.address_o); end
    checks++; if (bus.write_o !== 1'b0) begin errors++; $display("FAIL read_write_o: got %0h want 0", bus.write_o); end
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1; bus.burst_i = la[i*64 +: 64];
      step();
      if (i < 3) begin
        checks++; if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin errors++; $display("FAIL read_mid_beat%0d: read_o=%0h resp_o=%0h want 1/0", i, bus.read_o, bus.resp_o); end
      end
    end
    bus.resp_i = 1'b0;
    checks++; if (bus.resp_o !== 1'b1) begin errors++; $display("FAIL read_resp_o: got %0h want 1", bus.resp_o); end
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("FAIL read_drop_read_o: got %0h want 0", bus.read_o); end
    checks++; if (bus.line_o !== LINE_A) begin errors++; $display("FAIL read_line_o: got %h want %h", bus.line_o, LINE_A); end
    bus.read_i = 1'b0;
    step();
    checks++; if (bus.resp_o !== 1'b0) begin errors++; $display("FAIL read_resp_pulse: got %0h want 0", bus.resp_o); end
    checks++; if (bus.line_o !== LINE_A) begin errors++; $display("FAIL read_line_hold: got %h want %h", bus.line_o, LINE_A); end
  endtask

  task automatic test_write_gaps();
    line_t ld = LINE_D;
    int pat[6] = '{1, 0, 1, 1, 0, 1};
    int acc = 0;
    bus.write_i = 1'b1; bus.line_i = LINE_D; bus.address_i = 32'h0000_0040;
    step();
    bus.line_i = LINE_E; bus.address_i = 32'h0000_9999;
    checks++; if (bus.write_o !== 1'b1) begin errors++; $display("FAIL write_write_o: got %0h want 1", bus.write_o); end
    checks++; if (bus.address_o !== 32'h0000_0040) begin errors++; $display("FAIL write_address_o: got %h want 00000040", bus.address_o); end
    checks++; if (bus.read_o !== 1'b0) begin errors++; $display("FAIL write_read_o: got %0h want 0", bus.read_o); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.burst_o !== ld[acc*64 +: 64]) begin errors++; $display("FAIL write_burst_c%0d: got %h want %h", k, bus.burst_o, ld[acc*64 +: 64]); end
      checks++; if (bus.write_o !== 1'b1) begin errors++; $display("FAIL write_hold_c%0d: write_o got %0h want 1", k, bus.write_o); end
      bus.resp_i = pat[k][0];
      if (pat[k] == 1) acc++;
      step();
    end
    bus.resp_i = 1'b0;
    checks++; if (bus.write_o !== 1'b0) begin errors++; $display("FAIL write_drop: write_o got %0h want 0", bus.write_o); end
    checks++; if (bus.resp_o !== 1'b1) begin errors++; $display("FAIL write_resp_o: got %0h want 1", bus.resp_o); end
    checks++; if (bus.line_o !== LINE_A) begin errors++; $display("FAIL write_line_o_kept: got %h want %h", bus.line_o, LINE_A); end
    bus.write_i = 1'b0;
    step();
    checks++; if (bus.resp_o !== 1'b0 || bus.burst_o !== 64'h0) begin errors++; $display("FAIL write_idle: resp_o=%0h burst_o=%h want 0/0", bus.resp_o, bus.burst_o); end
  endtask

  task automatic test_resp_ignored();
    bus.resp_i = 1'b1; bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    step();
    bus.resp_i = 1'b0;
    checks++; if (bus.line_o !== LINE_A) begin errors++; $display("FAIL idle_resp_line_o: got %h want %h", bus.line_o, LINE_A); end
    checks++; if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin errors++; $display("FAIL idle_resp_outputs: rd=%0h wr=%0h resp=%0h want 0", bus.read_o, bus.write_o, bus.resp_o); end
    read_line(32'h0000_2000, LINE_B, 0);
    bus.resp_i = 1'b1; bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0; bus.read_i = 1'b0;
    step();
    bus.resp_i = 1'b0;
    checks++; if (bus.line_o !== LINE_B) begin errors++; $display("FAIL done_resp_line_o: got %h want %h", bus.line_o, LINE_B); end
    read_line(32'h0000_3000, LINE_C, 0);
    checks++; if (bus.line_o !== LINE_C || bus.resp_o !== 1'b1) begin errors++; $display("FAIL after_ignore_read: line_o=%h resp_o=%0h want %h/1", bus.line_o, bus.resp_o, LINE_C); end
    bus.read_i = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    line_t le = LINE_E;
    read_line(32'h0000_4000, LINE_B, 0);
    checks++; if (bus.resp_o !== 1'b1) begin errors++; $display("FAIL b2b_first_resp: got %0h want 1", bus.resp_o); end
    bus.read_i = 1'b0; bus.write_i = 1'b1; bus.line_i = LINE_E; bus.address_i = 32'h0000_5010;
    step();
    checks++; if (bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin errors++; $display("FAIL b2b_accept_cycle: write_o=%0h resp_o=%0h want 0/0", bus.write_o, bus.resp_o); end
    step();
    checks++; if (bus.write_o !== 1'b1 || bus.address_o !== 32'h0000_5000) begin errors++; $display("FAIL b2b_write_start: write_o=%0h addr=%h want 1/00005000", bus.write_o, bus.address_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.burst_o !== le[i*64 +: 64]) begin errors++; $display("FAIL b2b_burst%0d: got %h want %h", i, bus.burst_o, le[i*64 +: 64]); end
      bus.resp_i = 1'b1;
      step();
    end
    bus.resp_i = 1'b0;
    checks++; if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0) begin errors++; $display("FAIL b2b_done: resp_o=%0h write_o=%0h want 1/0", bus.resp_o, bus.write_o); end
    checks++; if (bus.line_o !== LINE_B) begin errors++; $display("FAIL b2b_line_o: got %h want %h", bus.line_o, LINE_B); end
    bus.write_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    line_t la = LINE_A;
    bus.read_i = 1'b1; bus.address_i = 32'h0000_6000;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.resp_i = 1'b1; bus.burst_i = la[i*64 +: 64];
      step();
    end
    checks++; if (bus.read_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: read_o got %0h want 1", bus.read_o); end
    rst = 1'b1; bus.resp_i = 1'b0;
    step();
    checks++; if (bus.read_o !== 1'b0 || bus.resp_o !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: read_o=%0h resp_o=%0h want 0/0", bus.read_o, bus.resp_o); end
    checks++; if (bus.line_o !== {LINE_W{1'b0}} || bus.address_o !== 32'h0) begin errors++; $display("FAIL rstmid_data: line_o=%h addr=%h want 0/0", bus.line_o, bus.address_o); end
    rst = 1'b0; bus.read_i = 1'b0;
    step();
    checks++; if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_resp: resp_o=%0h read_o=%0h want 0/0", bus.resp_o, bus.read_o); end
    read_line(32'h0000_7000, LINE_C, 0);
    checks++; if (bus.line_o !== LINE_C || bus.resp_o !== 1'b1) begin errors++; $display("FAIL rstmid_reread: line_o=%h resp_o=%0h want %h/1", bus.line_o, bus.resp_o, LINE_C); end
    bus.read_i = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.line_i = {LINE_W{1'b0}}; bus.address_i = 32'h0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = 64'h0; bus.resp_i = 1'b0;
    @(negedge clk);
    test_reset();
`ifdef CACHELINE_ADAPTOR_PERF_EN
    test_perf();
`endif
    test_read();
    test_write_gaps();
    test_resp_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
